pipe_mem_port_arbiter: RTL and testbench

- Sequences a single shared memory port between two requesters:
  - the IF stage, for instruction fetch;
  - the MEM stage, for load/store driven from the EX/MEM register outputs.
- Memory is variable-latency and signals completion with bus_ack.
- The block raises stall signals that freeze the pipeline until the owning request completes.
- Sits between the pipeline registers and the unified memory/IO bus.

---
 rtl/pipe_mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_pipe_mem_port_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_port_arbiter.sv
// pipe_mem_port_arbiter
// Sequences one shared, variable-latency memory port between the IF stage
// (instruction fetch) and the MEM stage (load/store). Data accesses have fixed
// priority over fetches because MEM holds the older instruction. Stall outputs
// freeze the pipeline until the owning request reaches its DONE cycle.
//
// Optional feature: define ARB_TIMEOUT_EN to abort a transfer after TIMEOUT
// cycles without bus_ack. An aborted transfer returns zero read data and sets
// the sticky bus_err flag. Without the macro the FSM waits for bus_ack
// indefinitely and bus_err is tied low.

module pipe_mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              resetn,
    // IF stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    // MEM stage (EX/MEM register outputs)
    input  logic              mm2reg,
    input  logic              mwmem,
    input  logic [ADDR_W-1:0] malu,
    input  logic [DATA_W-1:0] mb,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_done,
    // pipeline control
    output logic              stall_if,
    output logic              stall_mem,
    // unified memory/IO bus
    output logic              bus_en,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        INST,
        DONE_D,
        DONE_I
    } state_t;

    state_t state;
    logic   data_req;
    logic   timed_out;
    logic   abort;

    assign data_req = mm2reg | mwmem;

    // The pipeline only sees "done" in the DONE cycle, so stalls drop there.
    assign stall_mem = data_req & (state != DONE_D);
    assign stall_if  = stall_mem | (if_req & (state != DONE_I));

    // A timeout only aborts when the bus did not answer in that same cycle.
    assign abort = timed_out & ~bus_ack;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // The TIMEOUT-th wait cycle is the one where the counter shows TIMEOUT-1.
    assign timed_out = (state == DATA || state == INST) &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign bus_err   = err_q;

    // Wait-cycle counter, cleared on every entry into DATA/INST, and sticky error.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if ((state == DATA || state == INST) && !bus_ack) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (abort) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timed_out = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Arbitration FSM with registered bus outputs, read data and done pulses.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bus_en    <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            m_rdata   <= '0;
            if_done   <= 1'b0;
            m_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make the done flags one-cycle
            // pulses; the DATA/INST branches override them on completion.
            if_done <= 1'b0;
            m_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_req) begin
                        bus_en    <= 1'b1;
                        bus_we    <= mwmem;
                        bus_addr  <= malu;
                        bus_wdata <= mb;
                        state     <= DATA;
                    end else if (if_req) begin
                        bus_en   <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= if_addr;
                        state    <= INST;
                    end
                end
                DATA: begin
                    if (bus_ack || abort) begin
                        bus_en  <= 1'b0;
                        bus_we  <= 1'b0;
                        m_rdata <= (bus_ack && !bus_we) ? bus_rdata : '0;
                        m_done  <= 1'b1;
                        state   <= DONE_D;
                    end
                end
                INST: begin
                    if (bus_ack || abort) begin
                        bus_en   <= 1'b0;
                        bus_we   <= 1'b0;
                        if_rdata <= bus_ack ? bus_rdata : '0;
                        if_done  <= 1'b1;
                        state    <= DONE_I;
                    end
                end
                DONE_D:  state <= IDLE;
                DONE_I:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_port_arbiter.sv
// tb_pipe_mem_port_arbiter
// Scoreboard bench: stimulus pushes expected bus transactions and expected
// read data into queues; a monitor pops and compares whenever the DUT starts a
// bus transfer or pulses a done flag. A behavioural memory answers requests
// with a programmable ack delay. Build with ARB_TIMEOUT_EN to add the
// timeout scenario.

module tb_pipe_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } bus_exp_t;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          mm2reg = 1'b0;
    logic          mwmem = 1'b0;
    logic [AW-1:0] malu = '0;
    logic [DW-1:0] mb = '0;
    logic [DW-1:0] m_rdata;
    logic          m_done;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_en;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;
    logic          bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    bus_exp_t      exp_bus_q[$];
    logic [DW-1:0] exp_m_q[$];
    logic [DW-1:0] exp_i_q[$];
    logic          exp_err = 1'b0;

    bit resp_on   = 1'b0;
    int ack_delay = 0;
    int resp_cnt  = 0;

    pipe_mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mm2reg    (mm2reg),
        .mwmem     (mwmem),
        .malu      (malu),
        .mb        (mb),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory contents seen by the behavioural bus responder.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        case (a)
            32'h0000_0100: mem_val = 32'hDEAD_BEEF;
            32'h0000_0040: mem_val = 32'h00A0_0093;
            32'h0000_0080: mem_val = 32'hCAFE_F00D;
            default:       mem_val = a ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Bus responder: acks after ack_delay cycles of bus_en, garbage otherwise.
    initial begin
        forever begin
            @(negedge clock);
            if (resp_on) begin
                if (bus_en && resetn) begin
                    if (resp_cnt >= ack_delay) begin
                        bus_ack   = 1'b1;
                        bus_rdata = mem_val(bus_addr);
                        resp_cnt  = 0;
                    end else begin
                        bus_ack   = 1'b0;
                        bus_rdata = 32'hBAD0_BAD0;
                        resp_cnt++;
                    end
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = 32'hBAD0_BAD0;
                    resp_cnt  = 0;
                end
            end
        end
    end

    // Monitor: compares DUT activity against the scoreboard queues.
    initial begin
        bus_exp_t      e;
        logic [DW-1:0] d;
        logic          prev_en = 1'b0;
        logic          prev_we = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [DW-1:0] prev_wdata = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                prev_en = 1'b0;
            end else begin
                if (bus_en && !prev_en) begin
                    if (exp_bus_q.size() == 0) begin
                        check("bus_unexpected_start", {32'h0, bus_addr}, 64'h0);
                    end else begin
                        e = exp_bus_q.pop_front();
                        check("bus_addr", {32'h0, bus_addr}, {32'h0, e.addr});
                        check("bus_we", {63'h0, bus_we}, {63'h0, e.we});
                        if (e.we) check("bus_wdata", {32'h0, bus_wdata}, {32'h0, e.wdata});
                    end
                end
                if (bus_en && prev_en) begin
                    check("bus_hold", {bus_we, bus_addr, bus_wdata}, {prev_we, prev_addr, prev_wdata});
                end
                if (m_done) begin
                    if (exp_m_q.size() == 0) begin
                        check("m_done_unexpected", {32'h0, m_rdata}, 64'h0);
                    end else begin
                        d = exp_m_q.pop_front();
                        check("m_rdata", {32'h0, m_rdata}, {32'h0, d});
                    end
                    check("m_done_err", {63'h0, bus_err}, {63'h0, exp_err});
                    check("m_done_excl", {63'h0, if_done}, 64'h0);
                end
                if (if_done) begin
                    if (exp_i_q.size() == 0) begin
                        check("if_done_unexpected", {32'h0, if_rdata}, 64'h0);
                    end else begin
                        d = exp_i_q.pop_front();
                        check("if_rdata", {32'h0, if_rdata}, {32'h0, d});
                    end
                end
                prev_en    = bus_en;
                prev_we    = bus_we;
                prev_addr  = bus_addr;
                prev_wdata = bus_wdata;
            end
        end
    end

    // Bounded wait for a done pulse; returns negedges elapsed.
    task automatic wait_done(input bit is_data, output int cycles);
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 200) begin
            @(negedge clock);
            cycles++;
            seen = is_data ? (m_done === 1'b1) : (if_done === 1'b1);
        end
        if (!seen) check("done_wait_expired", 64'h0, 64'h1);
    endtask

    initial begin
        int cyc;
        int en_cycles;

        // Reset state
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_bus", {bus_en, bus_we, bus_addr, bus_wdata}, '0);
        check("rst_rdata", {if_rdata, m_rdata}, 64'h0);
        check("rst_done_err", {61'h0, if_done, m_done, bus_err}, 64'h0);
        check("rst_stalls", {62'h0, stall_if, stall_mem}, 64'h0);
        resetn  = 1'b1;
        resp_on = 1'b1;
        @(negedge clock);

        // Load, ack one cycle after bus_en
        ack_delay = 0;
        exp_bus_q.push_back('{addr: 32'h100, we: 1'b0, wdata: '0});
        exp_m_q.push_back(32'hDEAD_BEEF);
        mm2reg = 1'b1; malu = 32'h100; mb = 32'h77;
        @(negedge clock);
        check("ld_bus_en", {63'h0, bus_en}, 64'h1);
        check("ld_stall_busy", {62'h0, stall_if, stall_mem}, 64'h3);
        wait_done(1'b1, cyc);
        check("ld_latency", cyc, 1);
        check("ld_stall_done", {62'h0, stall_if, stall_mem}, 64'h0);
        @(negedge clock);
        mm2reg = 1'b0;
        check("ld_single_pulse", {63'h0, m_done}, 64'h0);

        // Store with 4-cycle ack delay; inputs change after acceptance
        ack_delay = 4;
        exp_bus_q.push_back('{addr: 32'h200, we: 1'b1, wdata: 32'h1234_5678});
        exp_m_q.push_back(32'h0);
        mwmem = 1'b1; malu = 32'h200; mb = 32'h1234_5678;
        @(negedge clock);
        malu = 32'h999; mb = 32'hFFFF_FFFF;
        wait_done(1'b1, cyc);
        check("st_latency", cyc, 5);
        @(negedge clock);
        mwmem = 1'b0;
        check("st_single_pulse", {63'h0, m_done}, 64'h0);

        // Simultaneous fetch and load: data first, fetch after DONE_D
        ack_delay = 1;
        exp_bus_q.push_back('{addr: 32'h80, we: 1'b0, wdata: '0});
        exp_bus_q.push_back('{addr: 32'h40, we: 1'b0, wdata: '0});
        exp_m_q.push_back(32'hCAFE_F00D);
        exp_i_q.push_back(32'h00A0_0093);
        if_req = 1'b1; if_addr = 32'h40;
        mm2reg = 1'b1; malu = 32'h80;
        wait_done(1'b1, cyc);
        check("sim_data_latency", cyc, 3);
        check("sim_stall_in_done_d", {62'h0, stall_if, stall_mem}, 64'h2);
        @(negedge clock);
        mm2reg = 1'b0;
        check("sim_idle_gap", {63'h0, bus_en}, 64'h0);
        check("sim_stall_if_idle", {63'h0, stall_if}, 64'h1);
        wait_done(1'b0, cyc);
        check("sim_inst_latency", cyc, 3);
        check("sim_stall_in_done_i", {62'h0, stall_if, stall_mem}, 64'h0);
        @(negedge clock);
        if_req = 1'b0;
        check("sim_if_single_pulse", {63'h0, if_done}, 64'h0);

        // Fetch only, 2-cycle ack delay
        ack_delay = 2;
        exp_bus_q.push_back('{addr: 32'h1004, we: 1'b0, wdata: '0});
        exp_i_q.push_back(32'h5A5A_1004);
        if_req = 1'b1; if_addr = 32'h1004;
        wait_done(1'b0, cyc);
        check("if_latency", cyc, 4);
        check("if_no_m_done", {63'h0, m_done}, 64'h0);
        @(negedge clock);
        if_req = 1'b0;

        // Reset during DATA, then a late ack while IDLE
        resp_on = 1'b0;
        bus_ack = 1'b0;
        exp_bus_q.push_back('{addr: 32'h300, we: 1'b1, wdata: 32'h55AA_55AA});
        mwmem = 1'b1; malu = 32'h300; mb = 32'h55AA_55AA;
        repeat (2) @(negedge clock);
        check("rmid_en_before", {63'h0, bus_en}, 64'h1);
        #2 resetn = 1'b0;
        #1;
        check("rmid_bus_dropped", {bus_en, bus_we, bus_addr, bus_wdata}, '0);
        check("rmid_out_zero", {m_rdata, if_rdata}, 64'h0);
        check("rmid_done_zero", {61'h0, m_done, if_done, bus_err}, 64'h0);
        mwmem = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hFEED_FACE;
        @(negedge clock);
        bus_ack = 1'b0;
        check("late_ack_1", {m_rdata, 29'h0, bus_en, m_done, if_done}, 64'h0);
        @(negedge clock);
        check("late_ack_2", {m_rdata, 29'h0, bus_en, m_done, if_done}, 64'h0);

        // Normal load after reset recovery proves the FSM sits in IDLE
        resp_on   = 1'b1;
        ack_delay = 0;
        exp_bus_q.push_back('{addr: 32'h100, we: 1'b0, wdata: '0});
        exp_m_q.push_back(32'hDEAD_BEEF);
        mm2reg = 1'b1; malu = 32'h100;
        wait_done(1'b1, cyc);
        check("post_rst_latency", cyc, 2);
        @(negedge clock);
        mm2reg = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // Timeout: no ack at all, abort after 15 wait cycles
        resp_on = 1'b0;
        bus_ack = 1'b0;
        exp_err = 1'b1;
        exp_bus_q.push_back('{addr: 32'h500, we: 1'b0, wdata: '0});
        exp_m_q.push_back(32'h0);
        mm2reg = 1'b1; malu = 32'h500;
        en_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (m_done) break;
            if (bus_en) en_cycles++;
        end
        check("to_wait_cycles", en_cycles, 15);
        check("to_err_set", {63'h0, bus_err}, 64'h1);
        @(negedge clock);
        mm2reg = 1'b0;

        // Good transfer afterwards: error stays sticky
        resp_on = 1'b1;
        exp_bus_q.push_back('{addr: 32'h100, we: 1'b0, wdata: '0});
        exp_m_q.push_back(32'hDEAD_BEEF);
        mm2reg = 1'b1; malu = 32'h100;
        wait_done(1'b1, cyc);
        @(negedge clock);
        mm2reg = 1'b0;
        check("to_err_sticky", {63'h0, bus_err}, 64'h1);
`else
        en_cycles = 0;
        check("err_tied_low", {63'h0, bus_err}, 64'h0);
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_drain", exp_bus_q.size() + exp_m_q.size() + exp_i_q.size() + en_cycles * 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
